gamma_lut_ctrl: RTL and testbench
=================================

Name: gamma_lut_ctrl

Overview:
Double-buffered gamma lookup-table controller for the LCD gray/gamma display path. It replaces the fixed gamma ROM with two 256x8 banks. The display side reads the active bank with 1-cycle latency, exactly like the ROM it replaces. A configuration byte stream loads a new 256-entry curve into the inactive bank, and the banks swap only at a frame boundary, so the displayed image never mixes two curves within one frame.

Parameters:
LUT_DEPTH, 256, entries per bank; the address width is fixed at 8 bits.
TIMEOUT_CYC, 1000000, idle cycles allowed between accepted bytes before a load is aborted (used only with GAMMA_LUT_TIMEOUT_EN).

Ports:
lcd_pclk  in  1  pixel clock; the only clock.
rst_n  in  1  asynchronous active-low reset.
frame_start  in  1  single-cycle pulse at the start of vertical blanking; this is the only instant a swap may occur.
cfg_start  in  1  pulse that begins or restarts a table load.
cfg_valid  in  1  cfg_data is valid.
cfg_data  in  8  table byte; bytes arrive in address order 0..255.
cfg_ready  out  1  controller accepts a byte this cycle.
rd_addr  in  8  lookup address (gray value).
rd_data  out  8  gamma-corrected value, registered.
active_bank  out  1  bank currently driving rd_data.
busy  out  1  high in LOAD or PEND.
swap_done  out  1  one-cycle pulse when a swap occurs.
load_err  out  1  sticky abort flag, cleared by cfg_start; tied 0 without GAMMA_LUT_TIMEOUT_EN.

Behaviour:
- Reset values of outputs:
  - cfg_ready=0, rd_data=0, active_bank=0, busy=0, swap_done=0, load_err=0.
  - Internal state: FSM=IDLE, wr_idx=0, lut_loaded=0.
  - Bank contents are not reset.
- Read path:
  - rd_data <= (lut_loaded ? bank[active_bank][rd_addr] : rd_addr).
  - Latency is 1 cycle, every cycle, with no stall.
  - Before the first successful swap the output is an identity map.
- FSM states: IDLE, LOAD, PEND.
- IDLE:
  - cfg_ready=0.
  - cfg_start -> LOAD, wr_idx=0, load_err cleared.
- LOAD:
  - cfg_ready=1.
  - A byte is accepted on cfg_valid&cfg_ready. It is written to bank[~active_bank][wr_idx], then wr_idx increments.
  - Acceptance of byte 255 -> PEND, and wr_idx wraps to 0.
  - cfg_start in LOAD restarts the load: wr_idx=0, any byte in that same cycle is discarded, and the state stays LOAD.
- PEND:
  - cfg_ready=0.
  - On frame_start: active_bank toggles, lut_loaded=1, swap_done=1 for one cycle, next state IDLE.
  - cfg_start in PEND returns to LOAD with wr_idx=0 and no swap; the partially replaced table is never shown.
- Simultaneous events:
  - Byte 255 accepted in the same cycle as frame_start: enter PEND, no swap that cycle. The swap happens at the next frame_start.
  - cfg_start together with frame_start in PEND: cfg_start wins and no swap occurs.
- Bank write/read conflicts:
  - Writes target only the inactive bank, so there is no read/write conflict.
  - The new active bank is visible on rd_data for lookups issued on the cycle after swap_done.
- Reset mid-load or mid-PEND: everything returns to reset values, and the identity map resumes.
- busy = (state != IDLE).

Optional Feature:
GAMMA_LUT_TIMEOUT_EN
- Defined:
  - An idle counter runs in LOAD and clears on each accepted byte or cfg_start.
  - When the counter reaches TIMEOUT_CYC-1: go to IDLE, set load_err=1, and leave active_bank untouched.
  - Counter width is $clog2(TIMEOUT_CYC).
- Undefined: no counter is built, load_err is constant 0, and LOAD waits indefinitely.

Test Plan:
- Reset, then drive rd_addr=0x37 -> rd_data=0x37 one cycle later; active_bank=0, busy=0.
- cfg_start, stream bytes i^0xFF for i=0..255 with cfg_valid held high -> PEND after 256 accepts, cfg_ready falls. Lookups still return identity until frame_start. Then swap_done pulses, active_bank=1, and rd_addr=0x10 -> 0xEF.
- Gapped stream (cfg_valid toggling every cycle) with a second table (all 0x80) -> after swap, any rd_addr -> 0x80 and active_bank=0. Verify the old bank was never read during the load.
- Assert cfg_start after 100 bytes, then stream 256 fresh bytes -> table equals the fresh bytes. Byte 255 accepted coincident with frame_start -> no swap until the following frame_start.
- cfg_start during PEND, then frame_start -> no swap_done and active_bank unchanged. Assert rst_n low mid-load -> identity output and all outputs at reset values.
- (GAMMA_LUT_TIMEOUT_EN, TIMEOUT_CYC=50) Stop after 10 bytes -> 50 cycles later state is IDLE, load_err=1, active_bank unchanged. A subsequent cfg_start clears load_err.

Source files
------------

// File: rtl/gamma_lut_ctrl.sv
// Double-buffered 256x8 gamma LUT: display reads the active bank, config loads the other,
// banks swap only on frame_start. Optional load timeout under `GAMMA_LUT_TIMEOUT_EN.
module gamma_lut_ctrl #(
`ifdef GAMMA_LUT_TIMEOUT_EN
   parameter int unsigned TIMEOUT_CYC = 1000000,
`endif
   parameter int unsigned LUT_DEPTH = 256
) (
   input  logic       lcd_pclk,
   input  logic       rst_n,
   input  logic       frame_start,
   input  logic       cfg_start,
   input  logic       cfg_valid,
   input  logic [7:0] cfg_data,
   output logic       cfg_ready,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       active_bank,
   output logic       busy,
   output logic       swap_done,
   output logic       load_err
);

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
   localparam logic [AW-1:0] LAST_IDX = AW'(LUT_DEPTH - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_PEND = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] wr_idx_nxt;
   logic          lut_loaded;
   logic          accept;
   logic          do_swap;
   logic          idle_expired;
   logic [DW-1:0] lut_val;

   logic [DW-1:0] bank0 [LUT_DEPTH];
   logic [DW-1:0] bank1 [LUT_DEPTH];

   // Next-state logic; cfg_start has priority over bytes and frame_start
   always_comb begin
      state_nxt  = state;
      wr_idx_nxt = wr_idx;
      accept     = 1'b0;
      do_swap    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cfg_start) begin
               state_nxt  = ST_LOAD;
               wr_idx_nxt = '0;
            end
         end
         ST_LOAD: begin
            if (cfg_start) begin
               wr_idx_nxt = '0;
            end else if (cfg_valid && cfg_ready) begin
               accept     = 1'b1;
               wr_idx_nxt = wr_idx + AW'(1);
               if (wr_idx == LAST_IDX) begin
                  state_nxt  = ST_PEND;
                  wr_idx_nxt = '0;
               end
            end else if (idle_expired) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_PEND: begin
            if (cfg_start) begin
               state_nxt  = ST_LOAD;
               wr_idx_nxt = '0;
            end else if (frame_start) begin
               do_swap   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt  = ST_IDLE;
            wr_idx_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         wr_idx      <= '0;
         lut_loaded  <= 1'b0;
         active_bank <= 1'b0;
         swap_done   <= 1'b0;
         cfg_ready   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state     <= state_nxt;
         wr_idx    <= wr_idx_nxt;
         swap_done <= do_swap;
         cfg_ready <= (state_nxt == ST_LOAD);
         busy      <= (state_nxt != ST_IDLE);
         if (do_swap) begin
            active_bank <= ~active_bank;
            lut_loaded  <= 1'b1;
         end
      end
   end

   // Loads always target the bank not currently displayed
   always_ff @(posedge lcd_pclk) begin
      if (accept) begin
         if (active_bank) begin
            bank0[wr_idx] <= cfg_data;
         end else begin
            bank1[wr_idx] <= cfg_data;
         end
      end
   end

   assign lut_val = active_bank ? bank1[rd_addr] : bank0[rd_addr];

   // Identity map until the first curve has been swapped in
   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else begin
         rd_data <= lut_loaded ? lut_val : rd_addr;
      end
   end

`ifdef GAMMA_LUT_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYC);

   logic [CW-1:0] idle_cnt;

   assign idle_expired = (idle_cnt == CW'(TIMEOUT_CYC - 1));

   // Counts LOAD cycles since the last accepted byte or restart
   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if ((state != ST_LOAD) || cfg_start || accept || idle_expired) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + CW'(1);
      end
   end

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         load_err <= 1'b0;
      end else if (cfg_start) begin
         load_err <= 1'b0;
      end else if ((state == ST_LOAD) && !(cfg_valid && cfg_ready) && idle_expired) begin
         load_err <= 1'b1;
      end
   end
`else
   assign idle_expired = 1'b0;
   assign load_err     = 1'b0;
`endif

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Directed self-checking bench for gamma_lut_ctrl (timeout test runs with GAMMA_LUT_TIMEOUT_EN).
module tb_gamma_lut_ctrl;

   logic       lcd_pclk;
   logic       rst_n;
   logic       frame_start;
   logic       cfg_start;
   logic       cfg_valid;
   logic [7:0] cfg_data;
   logic       cfg_ready;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       active_bank;
   logic       busy;
   logic       swap_done;
   logic       load_err;

   int checks = 0;
   int errors = 0;

`ifdef GAMMA_LUT_TIMEOUT_EN
   gamma_lut_ctrl #(.TIMEOUT_CYC(50)) dut (
`else
   gamma_lut_ctrl dut (
`endif
      .lcd_pclk    (lcd_pclk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .cfg_start   (cfg_start),
      .cfg_valid   (cfg_valid),
      .cfg_data    (cfg_data),
      .cfg_ready   (cfg_ready),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .active_bank (active_bank),
      .busy        (busy),
      .swap_done   (swap_done),
      .load_err    (load_err)
   );

   initial begin
      lcd_pclk = 1'b0;
      forever #5 lcd_pclk = ~lcd_pclk;
   end

   task automatic tick();
      @(posedge lcd_pclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      cfg_valid = 1'b1;
      cfg_data  = d;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_start();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      frame_start = 1'b0;
      cfg_start   = 1'b0;
      cfg_valid   = 1'b0;
      cfg_data    = 8'h00;
      rd_addr     = 8'h00;
      repeat (3) tick();

      // Reset values
      chk("rst_cfg_ready", {7'd0, cfg_ready}, 8'd0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_active_bank", {7'd0, active_bank}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_swap_done", {7'd0, swap_done}, 8'd0);
      chk("rst_load_err", {7'd0, load_err}, 8'd0);

      rst_n = 1'b1;
      tick();
      rd_addr = 8'h37;
      tick();
      chk("identity_37", rd_data, 8'h37);
      chk("idle_busy", {7'd0, busy}, 8'd0);

      // Table 1: i ^ 0xFF, continuous stream
      pulse_start();
      chk("load_cfg_ready", {7'd0, cfg_ready}, 8'd1);
      chk("load_busy", {7'd0, busy}, 8'd1);
      rd_addr = 8'h10;
      for (int i = 0; i < 256; i++) send(8'(i) ^ 8'hFF);
      chk("pend_cfg_ready", {7'd0, cfg_ready}, 8'd0);
      chk("pend_busy", {7'd0, busy}, 8'd1);
      chk("pend_identity", rd_data, 8'h10);
      chk("pend_bank", {7'd0, active_bank}, 8'd0);
      tick();
      chk("pend_no_swap", {7'd0, swap_done}, 8'd0);

      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("swap1_done", {7'd0, swap_done}, 8'd1);
      chk("swap1_bank", {7'd0, active_bank}, 8'd1);
      chk("swap1_busy", {7'd0, busy}, 8'd0);
      tick();
      chk("swap1_pulse_end", {7'd0, swap_done}, 8'd0);
      chk("t1_addr10", rd_data, 8'hEF);

      // Table 2: all 0x80, cfg_valid toggling; bank 1 must keep serving reads
      pulse_start();
      for (int i = 0; i < 512; i++) begin
         rd_addr   = 8'(i);
         cfg_valid = (i % 2 == 0);
         cfg_data  = 8'h80;
         tick();
         if (i % 16 == 0) chk("t1_during_load", rd_data, 8'(i) ^ 8'hFF);
      end
      cfg_valid = 1'b0;
      chk("gap_pend_ready", {7'd0, cfg_ready}, 8'd0);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("swap2_done", {7'd0, swap_done}, 8'd1);
      chk("swap2_bank", {7'd0, active_bank}, 8'd0);
      rd_addr = 8'h00;
      tick();
      chk("t2_addr00", rd_data, 8'h80);
      rd_addr = 8'hFF;
      tick();
      chk("t2_addrFF", rd_data, 8'h80);

      // Restart after 100 bytes, then fresh table 3*i+5; last byte with frame_start
      pulse_start();
      for (int i = 0; i < 100; i++) send(8'h11);
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = 8'h22;
      tick();
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      chk("restart_ready", {7'd0, cfg_ready}, 8'd1);
      for (int i = 0; i < 255; i++) send(8'(3 * i + 5));
      frame_start = 1'b1;
      send(8'(3 * 255 + 5));
      frame_start = 1'b0;
      chk("coinc_no_swap", {7'd0, swap_done}, 8'd0);
      chk("coinc_bank", {7'd0, active_bank}, 8'd0);
      chk("coinc_pend", {7'd0, cfg_ready}, 8'd0);
      chk("coinc_busy", {7'd0, busy}, 8'd1);
      rd_addr = 8'h64;
      tick();
      chk("coinc_old_table", rd_data, 8'h80);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("swap3_done", {7'd0, swap_done}, 8'd1);
      chk("swap3_bank", {7'd0, active_bank}, 8'd1);
      rd_addr = 8'h00;
      tick();
      chk("t3_addr00", rd_data, 8'h05);
      rd_addr = 8'h01;
      tick();
      chk("t3_addr01", rd_data, 8'h08);
      rd_addr = 8'h64;
      tick();
      chk("t3_addr64", rd_data, 8'h31);
      rd_addr = 8'hFF;
      tick();
      chk("t3_addrFF", rd_data, 8'h02);

      // cfg_start beats frame_start in PEND
      pulse_start();
      for (int i = 0; i < 256; i++) send(8'h55);
      chk("t4_pend", {7'd0, cfg_ready}, 8'd0);
      cfg_start   = 1'b1;
      frame_start = 1'b1;
      tick();
      cfg_start   = 1'b0;
      chk("pend_restart_no_swap", {7'd0, swap_done}, 8'd0);
      chk("pend_restart_bank", {7'd0, active_bank}, 8'd1);
      chk("pend_restart_load", {7'd0, cfg_ready}, 8'd1);
      tick();
      frame_start = 1'b0;
      chk("load_frame_no_swap", {7'd0, swap_done}, 8'd0);
      chk("load_frame_bank", {7'd0, active_bank}, 8'd1);
      rd_addr = 8'h00;
      tick();
      chk("t3_still_shown", rd_data, 8'h05);

      // Async reset in the middle of a load
      for (int i = 0; i < 20; i++) send(8'h99);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_rd_data", rd_data, 8'h00);
      chk("mid_rst_bank", {7'd0, active_bank}, 8'd0);
      chk("mid_rst_busy", {7'd0, busy}, 8'd0);
      chk("mid_rst_ready", {7'd0, cfg_ready}, 8'd0);
      chk("mid_rst_swap", {7'd0, swap_done}, 8'd0);
      tick();
      rst_n = 1'b1;
      rd_addr = 8'h5A;
      tick();
      chk("post_rst_identity", rd_data, 8'h5A);
      chk("post_rst_bank", {7'd0, active_bank}, 8'd0);

`ifdef GAMMA_LUT_TIMEOUT_EN
      // Timeout: 10 bytes then silence
      begin
         int waited;
         waited = 0;
         pulse_start();
         for (int i = 0; i < 10; i++) send(8'(i));
         while (busy && waited < 200) begin
            tick();
            waited++;
         end
         chk("to_cycles", 8'(waited), 8'd50);
         chk("to_busy", {7'd0, busy}, 8'd0);
         chk("to_ready", {7'd0, cfg_ready}, 8'd0);
         chk("to_load_err", {7'd0, load_err}, 8'd1);
         chk("to_bank", {7'd0, active_bank}, 8'd0);
         pulse_start();
         chk("to_err_cleared", {7'd0, load_err}, 8'd0);
         chk("to_reload_busy", {7'd0, busy}, 8'd1);
      end
`else
      // No timeout: LOAD waits indefinitely
      pulse_start();
      for (int i = 0; i < 10; i++) send(8'(i));
      repeat (300) tick();
      chk("nto_busy", {7'd0, busy}, 8'd1);
      chk("nto_load_err", {7'd0, load_err}, 8'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
